// File: rtl/mem_wb_pipe_if.sv
// MEM/WB pipeline bus: MEM-stage inputs, pipeline controls and the registered WB-stage view.
// The pipe register connects through the slave modport; the MEM-stage side uses master.
interface mem_wb_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic              stall_i;
    logic              flush_i;
    logic              cnt_clr_i;
    logic              valid_i;
    logic              RegWrite_i;
    logic              MemtoReg_i;
    logic [DATA_W-1:0] ALUresult_i;
    logic [DATA_W-1:0] Readdata_i;
    logic [ADDR_W-1:0] RDaddr_i;

    logic              valid_o;
    logic              RegWrite_o;
    logic              MemtoReg_o;
    logic [DATA_W-1:0] ALUresult_o;
    logic [DATA_W-1:0] Readdata_o;
    logic [ADDR_W-1:0] RDaddr_o;
    logic [DATA_W-1:0] WBdata_o;
    logic [CNT_W-1:0]  retire_cnt_o;

    modport master (
        output stall_i, flush_i, cnt_clr_i, valid_i, RegWrite_i, MemtoReg_i,
               ALUresult_i, Readdata_i, RDaddr_i,
        input  valid_o, RegWrite_o, MemtoReg_o, ALUresult_o, Readdata_o,
               RDaddr_o, WBdata_o, retire_cnt_o
    );

    modport slave (
        input  stall_i, flush_i, cnt_clr_i, valid_i, RegWrite_i, MemtoReg_i,
               ALUresult_i, Readdata_i, RDaddr_i,
        output valid_o, RegWrite_o, MemtoReg_o, ALUresult_o, Readdata_o,
               RDaddr_o, WBdata_o, retire_cnt_o
    );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with flush/stall control, x0 write suppression and
// a retired-instruction counter. Every output is a register or a mux of registers.
module mem_wb_pipe #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter int CNT_W         = 32,
    parameter int ZERO_SUPPRESS = 1
) (
    input logic           clk_i,
    input logic           rst_i,
    mem_wb_pipe_if.slave  bus
);

    logic              valid_r,     valid_s;
    logic              regwrite_r,  regwrite_s;
    logic              memtoreg_r,  memtoreg_s;
    logic [DATA_W-1:0] aluresult_r, aluresult_s;
    logic [DATA_W-1:0] readdata_r,  readdata_s;
    logic [ADDR_W-1:0] rdaddr_r,    rdaddr_s;
    logic [CNT_W-1:0]  cnt_r,       cnt_s;
    logic              advance_s;

    // Register-file write enable; a write aimed at index 0 is dropped when suppression is on.
    function automatic logic wr_enable(input logic rw, input logic v, input logic [ADDR_W-1:0] rd);
        logic zero_hit;
        zero_hit = (ZERO_SUPPRESS != 0) && (rd == {ADDR_W{1'b0}});
        return rw & v & ~zero_hit;
    endfunction

    // Next-state selection: flush beats stall, stall beats capture; clear beats increment.
    always_comb begin
        valid_s     = valid_r;
        regwrite_s  = regwrite_r;
        memtoreg_s  = memtoreg_r;
        aluresult_s = aluresult_r;
        readdata_s  = readdata_r;
        rdaddr_s    = rdaddr_r;
        cnt_s       = cnt_r;
        advance_s   = ~bus.flush_i & ~bus.stall_i;

        if (bus.flush_i) begin
            valid_s     = 1'b0;
            regwrite_s  = 1'b0;
            memtoreg_s  = 1'b0;
            aluresult_s = '0;
            readdata_s  = '0;
            rdaddr_s    = '0;
        end else if (bus.stall_i) begin
            valid_s     = valid_r;
            regwrite_s  = regwrite_r;
            memtoreg_s  = memtoreg_r;
            aluresult_s = aluresult_r;
            readdata_s  = readdata_r;
            rdaddr_s    = rdaddr_r;
        end else begin
            valid_s     = bus.valid_i;
            regwrite_s  = wr_enable(bus.RegWrite_i, bus.valid_i, bus.RDaddr_i);
            memtoreg_s  = bus.MemtoReg_i & bus.valid_i;
            aluresult_s = bus.ALUresult_i;
            readdata_s  = bus.Readdata_i;
            rdaddr_s    = bus.RDaddr_i;
        end

        // A held slot is counted only once, on the edge that actually lets it through.
        if (bus.cnt_clr_i) begin
            cnt_s = '0;
        end else if (advance_s && bus.valid_i) begin
            cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Stage registers and retire counter, cleared immediately by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_r     <= 1'b0;
            regwrite_r  <= 1'b0;
            memtoreg_r  <= 1'b0;
            aluresult_r <= '0;
            readdata_r  <= '0;
            rdaddr_r    <= '0;
            cnt_r       <= '0;
        end else begin
            valid_r     <= valid_s;
            regwrite_r  <= regwrite_s;
            memtoreg_r  <= memtoreg_s;
            aluresult_r <= aluresult_s;
            readdata_r  <= readdata_s;
            rdaddr_r    <= rdaddr_s;
            cnt_r       <= cnt_s;
        end
    end

    assign bus.valid_o      = valid_r;
    assign bus.RegWrite_o   = regwrite_r;
    assign bus.MemtoReg_o   = memtoreg_r;
    assign bus.ALUresult_o  = aluresult_r;
    assign bus.Readdata_o   = readdata_r;
    assign bus.RDaddr_o     = rdaddr_r;
    assign bus.retire_cnt_o = cnt_r;
    // Both candidates are zero in reset, so the write-back value is zero there too.
    assign bus.WBdata_o     = memtoreg_r ? readdata_r : aluresult_r;

endmodule
